// File: rtl/uart_cmd_pkg.sv
// Shared ASCII constants, FSM state encoding and byte helpers for the UART
// command dispatcher.
package uart_cmd_pkg;

  localparam logic [7:0] ASC_COMMA = 8'h2C;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_NINE  = 8'h39;
  localparam logic [7:0] ASC_K     = 8'h4B;
  localparam logic [7:0] ASC_E     = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MODE  = 3'd1,
    ST_COLON = 3'd2,
    ST_ARG   = 3'd3,
    ST_RESP1 = 3'd4,
    ST_RESP2 = 3'd5
  } state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASC_ZERO) && (b <= ASC_NINE);
  endfunction

endpackage

// File: rtl/uart_resp_tx.sv
// Response byte sequencer: launches the status byte, then the trailing CR once
// the UART reports the first byte finished.
module uart_resp_tx
  import uart_cmd_pkg::*;
(
  input  logic       iCLK,
  input  logic       RST_n,
  input  logic       resp_go,
  input  logic [7:0] resp_byte,
  input  logic       in_resp1,
  input  logic       SEND_END,
  output logic       TX_START,
  output logic [7:0] txd
);

  // txd is only reloaded together with TX_START, so it stays stable while the
  // UART is shifting the byte out.
  always_ff @(posedge iCLK or negedge RST_n) begin
    if (!RST_n) begin
      TX_START <= 1'b0;
      txd      <= 8'h00;
    end else begin
      TX_START <= 1'b0;
      if (resp_go) begin
        TX_START <= 1'b1;
        txd      <= resp_byte;
      end else if (in_resp1 && SEND_END) begin
        TX_START <= 1'b1;
        txd      <= ASC_CR;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_dispatch.sv
// Parses ",M:DDD<CR>" command frames from a UART receiver, publishes the
// decoded command and answers with "K<CR>" or "E<CR>".
module uart_cmd_dispatch
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000000,
  parameter int MAX_MODE    = 7
) (
  input  logic       iCLK,
  input  logic       RST_n,
  input  logic       RECEIVE_END,
  input  logic [7:0] rxd,
  input  logic       SEND_END,
  output logic       TX_START,
  output logic [7:0] txd,
  output logic       cmd_valid,
  output logic [3:0] cmd_mode,
  output logic [9:0] cmd_arg,
  output logic       busy
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    MODE_TOP = ASC_ZERO + 8'(MAX_MODE);

  state_t        state_reg;
  logic [3:0]    mode_reg;
  logic [9:0]    acc_reg;
  logic [1:0]    cnt_reg;
  logic [TW-1:0] to_cnt_reg;
  logic          resp_go_reg;
  logic [7:0]    resp_byte_reg;

  logic [9:0] acc_next;
  assign acc_next = acc_reg * 10'd10 + {6'd0, rxd[3:0]};

  always_ff @(posedge iCLK or negedge RST_n) begin
    if (!RST_n) begin
      state_reg     <= ST_IDLE;
      mode_reg      <= 4'd0;
      acc_reg       <= 10'd0;
      cnt_reg       <= 2'd0;
      to_cnt_reg    <= '0;
      resp_go_reg   <= 1'b0;
      resp_byte_reg <= 8'h00;
      cmd_valid     <= 1'b0;
      cmd_mode      <= 4'd0;
      cmd_arg       <= 10'd0;
    end else begin
      cmd_valid   <= 1'b0;
      resp_go_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          to_cnt_reg <= '0;
          if (RECEIVE_END && rxd == ASC_COMMA) state_reg <= ST_MODE;
        end
        ST_MODE, ST_COLON, ST_ARG: begin
          // A byte arriving on the expiry cycle wins over the timeout.
          if (RECEIVE_END) begin
            to_cnt_reg <= '0;
            if (rxd == ASC_COMMA) begin
              state_reg <= ST_MODE;
            end else if (state_reg == ST_MODE) begin
              if (is_digit(rxd) && rxd <= MODE_TOP) begin
                mode_reg  <= rxd[3:0];
                state_reg <= ST_COLON;
              end else begin
                state_reg     <= ST_RESP1;
                resp_go_reg   <= 1'b1;
                resp_byte_reg <= ASC_E;
              end
            end else if (state_reg == ST_COLON) begin
              if (rxd == ASC_COLON) begin
                acc_reg   <= 10'd0;
                cnt_reg   <= 2'd0;
                state_reg <= ST_ARG;
              end else begin
                state_reg     <= ST_RESP1;
                resp_go_reg   <= 1'b1;
                resp_byte_reg <= ASC_E;
              end
            end else if (is_digit(rxd) && cnt_reg != 2'd3) begin
              acc_reg <= acc_next;
              cnt_reg <= cnt_reg + 2'd1;
            end else if (rxd == ASC_CR && cnt_reg != 2'd0) begin
              cmd_valid     <= 1'b1;
              cmd_mode      <= mode_reg;
              cmd_arg       <= acc_reg;
              state_reg     <= ST_RESP1;
              resp_go_reg   <= 1'b1;
              resp_byte_reg <= ASC_K;
            end else begin
              state_reg     <= ST_RESP1;
              resp_go_reg   <= 1'b1;
              resp_byte_reg <= ASC_E;
            end
          end else if (to_cnt_reg == TO_LAST) begin
            to_cnt_reg <= '0;
            state_reg  <= ST_IDLE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        ST_RESP1: begin
          to_cnt_reg <= '0;
          if (SEND_END) state_reg <= ST_RESP2;
        end
        ST_RESP2: begin
          to_cnt_reg <= '0;
          if (SEND_END) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_reg != ST_IDLE);

  uart_resp_tx u_resp_tx (
    .iCLK      (iCLK),
    .RST_n     (RST_n),
    .resp_go   (resp_go_reg),
    .resp_byte (resp_byte_reg),
    .in_resp1  (state_reg == ST_RESP1),
    .SEND_END  (SEND_END),
    .TX_START  (TX_START),
    .txd       (txd)
  );

endmodule

// File: tb/tb_uart_cmd_dispatch.sv
// Directed bench for uart_cmd_dispatch with a behavioural UART TX responder.
module tb_uart_cmd_dispatch;

  localparam int ACK_DELAY = 5;

  logic       iCLK;
  logic       RST_n;
  logic       RECEIVE_END;
  logic [7:0] rxd;
  logic       SEND_END;
  logic       TX_START;
  logic [7:0] txd;
  logic       cmd_valid;
  logic [3:0] cmd_mode;
  logic [9:0] cmd_arg;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] tx_log[$];
  int         cv_count = 0;
  logic [3:0] last_mode = 4'd0;
  logic [9:0] last_arg = 10'd0;
  int         tx_viol = 0;
  int         hold_err = 0;
  bit         tx_outstanding = 0;
  int         ack_cd = 0;

  uart_cmd_dispatch #(.TIMEOUT_CYC(100), .MAX_MODE(7)) dut (
    .iCLK        (iCLK),
    .RST_n       (RST_n),
    .RECEIVE_END (RECEIVE_END),
    .rxd         (rxd),
    .SEND_END    (SEND_END),
    .TX_START    (TX_START),
    .txd         (txd),
    .cmd_valid   (cmd_valid),
    .cmd_mode    (cmd_mode),
    .cmd_arg     (cmd_arg),
    .busy        (busy)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Observes DUT outputs and plays the UART transmitter (SEND_END after ACK_DELAY).
  initial begin
    SEND_END = 1'b0;
    forever begin
      @(negedge iCLK);
      if (!RST_n) begin
        tx_outstanding = 0;
        ack_cd = 0;
      end else begin
        if (cmd_valid) begin
          cv_count++;
          last_mode = cmd_mode;
          last_arg = cmd_arg;
        end
        if (tx_outstanding && txd !== tx_log[$]) hold_err++;
        if (TX_START) begin
          if (tx_outstanding) tx_viol++;
          tx_log.push_back(txd);
          $display("tx byte 0x%02h", txd);
          tx_outstanding = 1;
          ack_cd = ACK_DELAY;
        end
      end
      SEND_END = 1'b0;
      if (ack_cd > 0) begin
        ack_cd--;
        if (ack_cd == 0) begin
          SEND_END = 1'b1;
          tx_outstanding = 0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge iCLK);
    rxd = b;
    RECEIVE_END = 1'b1;
    @(negedge iCLK);
    RECEIVE_END = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge iCLK);
      #1;
      if (!busy) break;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: busy=%b required 0", tag, busy);
    end
    repeat (3) @(negedge iCLK);
    #1;
  endtask

  task automatic clear_log();
    tx_log.delete();
    cv_count = 0;
    tx_viol = 0;
    hold_err = 0;
  endtask

  task automatic check_resp(input string tag, input logic [7:0] r);
    n_checks++;
    if (tx_log.size() != 2) begin
      n_fail++;
      $display("FAIL %s_txcount: got %0d bytes required 2", tag, tx_log.size());
    end else begin
      n_checks++;
      if (tx_log[0] !== r || tx_log[1] !== 8'h0D) begin
        n_fail++;
        $display("FAIL %s_txbytes: got %02h %02h required %02h 0d", tag, tx_log[0], tx_log[1], r);
      end
    end
    n_checks++;
    if (tx_viol != 0 || hold_err != 0) begin
      n_fail++;
      $display("FAIL %s_handshake: early restarts=%0d txd changes=%0d required 0 0", tag, tx_viol, hold_err);
    end
  endtask

  task automatic check_cmd(input string tag, input int cv, input logic [3:0] m, input logic [9:0] a);
    n_checks++;
    if (cv_count != cv) begin
      n_fail++;
      $display("FAIL %s_cvcount: got %0d required %0d", tag, cv_count, cv);
    end
    n_checks++;
    if (cmd_mode !== m || cmd_arg !== a) begin
      n_fail++;
      $display("FAIL %s_cmd: mode=%0d arg=%0d required mode=%0d arg=%0d", tag, cmd_mode, cmd_arg, m, a);
    end
    $display("frame %s: cmd_valid pulses=%0d mode=%0d arg=%0d", tag, cv_count, cmd_mode, cmd_arg);
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    RECEIVE_END = 1'b0;
    rxd = 8'h00;
    repeat (3) @(negedge iCLK);
    #1;
    n_checks++;
    if (TX_START !== 1'b0 || txd !== 8'h00 || cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tx: TX_START=%b txd=%02h cmd_valid=%b required 0 00 0", TX_START, txd, cmd_valid);
    end
    n_checks++;
    if (cmd_mode !== 4'd0 || cmd_arg !== 10'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cmd: mode=%0d arg=%0d busy=%b required 0 0 0", cmd_mode, cmd_arg, busy);
    end
    @(negedge iCLK);
    RST_n = 1'b1;
    repeat (2) @(negedge iCLK);
  endtask

  task automatic test_accept();
    clear_log();
    send_str(",3:125");
    send_byte(8'h0D);
    #1;
    n_checks++;
    if (cmd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_cv_timing: cmd_valid=%b required 1 the cycle after CR", cmd_valid);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_busy: busy=%b required 1 during response", busy);
    end
    wait_idle("accept");
    check_cmd("accept", 1, 4'd3, 10'd125);
    n_checks++;
    if (last_mode !== 4'd3 || last_arg !== 10'd125) begin
      n_fail++;
      $display("FAIL accept_pulse_val: mode=%0d arg=%0d required 3 125", last_mode, last_arg);
    end
    check_resp("accept", 8'h4B);
  endtask

  task automatic test_bad_mode();
    clear_log();
    send_str(",9:1");
    send_byte(8'h0D);
    wait_idle("bad_mode");
    check_cmd("bad_mode", 0, 4'd3, 10'd125);
    check_resp("bad_mode", 8'h45);
  endtask

  task automatic test_four_digits();
    clear_log();
    send_str(",2:1234");
    send_byte(8'h0D);
    wait_idle("four_digits");
    check_cmd("four_digits", 0, 4'd3, 10'd125);
    check_resp("four_digits", 8'h45);
  endtask

  task automatic test_restart();
    clear_log();
    send_str(",2:5,4:7");
    send_byte(8'h0D);
    wait_idle("restart");
    check_cmd("restart", 1, 4'd4, 10'd7);
    check_resp("restart", 8'h4B);
  endtask

  task automatic test_timeout();
    clear_log();
    send_str(",1:");
    repeat (90) @(negedge iCLK);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early: busy=%b required 1 after 90 silent cycles", busy);
    end
    repeat (20) @(negedge iCLK);
    #1;
    n_checks++;
    if (busy !== 1'b0 || tx_log.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_expire: busy=%b tx bytes=%0d required 0 0", busy, tx_log.size());
    end
    send_str(",1:0");
    send_byte(8'h0D);
    wait_idle("timeout_after");
    check_cmd("timeout_after", 1, 4'd1, 10'd0);
    check_resp("timeout_after", 8'h4B);
  endtask

  task automatic test_back_to_back();
    clear_log();
    send_str(",7:9");
    send_byte(8'h0D);
    wait_idle("b2b_first");
    check_cmd("b2b_first", 1, 4'd7, 10'd9);
    send_str(",0:42");
    send_byte(8'h0D);
    wait_idle("b2b_second");
    check_cmd("b2b_second", 2, 4'd0, 10'd42);
    n_checks++;
    if (tx_log.size() != 4) begin
      n_fail++;
      $display("FAIL b2b_txcount: got %0d bytes required 4", tx_log.size());
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_log();
    send_str(",5:42");
    send_byte(8'h0D);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge iCLK);
      #1;
      if (tx_log.size() > 0) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rst_mid_start: no TX_START within 10 cycles, required one");
    end
    RST_n = 1'b0;
    #1;
    n_checks++;
    if (TX_START !== 1'b0 || busy !== 1'b0 || cmd_valid !== 1'b0 || cmd_mode !== 4'd0 || cmd_arg !== 10'd0) begin
      n_fail++;
      $display("FAIL rst_mid_state: TX_START=%b busy=%b cv=%b mode=%0d arg=%0d required all 0",
               TX_START, busy, cmd_valid, cmd_mode, cmd_arg);
    end
    repeat (3) @(negedge iCLK);
    RST_n = 1'b1;
    clear_log();
    repeat (20) @(negedge iCLK);
    #1;
    n_checks++;
    if (tx_log.size() != 0 || cv_count != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: tx bytes=%0d cv=%0d busy=%b required 0 0 0", tx_log.size(), cv_count, busy);
    end
    send_str(",6:999");
    send_byte(8'h0D);
    wait_idle("rst_mid_fresh");
    check_cmd("rst_mid_fresh", 1, 4'd6, 10'd999);
    check_resp("rst_mid_fresh", 8'h4B);
  endtask

  initial begin
    test_reset();
    test_accept();
    test_bad_mode();
    test_four_digits();
    test_restart();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_dispatch.md
UART_CMD_DISPATCH -- requirements
Module: uart_cmd_dispatch

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1000000, inter-byte timeout in iCLK cycles.
REQ-002 SHALL have parameter MAX_MODE, default 7, highest accepted mode digit (0..9).
REQ-003 SHALL have port iCLK  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port RST_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port RECEIVE_END  input  1  one-cycle strobe, rxd valid.
REQ-006 SHALL have port rxd  input  8  received ASCII byte.
REQ-007 SHALL have port SEND_END  input  1  one-cycle strobe, UART TX finished the current byte.
REQ-008 SHALL have port TX_START  output  1  one-cycle request to transmit txd.
REQ-009 SHALL have port txd  output  8  byte to transmit, held stable from TX_START until SEND_END.
REQ-010 SHALL have port cmd_valid  output  1  one-cycle strobe, command accepted.
REQ-011 SHALL have port cmd_mode  output  4  mode digit of the last accepted command.
REQ-012 SHALL have port cmd_arg  output  10  binary argument (0..999) of the last accepted command.
REQ-013 SHALL have port busy  output  1  high while any state other than IDLE.

Function
REQ-014 Frame format SHALL be ',' M ':' D{1..3} CR(0x0D), where M is an ASCII digit 0..MAX_MODE and D is an ASCII digit.
REQ-015 FSM states SHALL be IDLE, MODE, COLON, ARG, RESP1, RESP2; bytes are consumed only on cycles with RECEIVE_END=1.
REQ-016 IDLE: ',' -> MODE; any other byte is ignored.
REQ-017 MODE: digit <= MAX_MODE -> latch mode, -> COLON; any other byte -> error response.
REQ-018 COLON: ':' -> ARG with arg accumulator=0 and digit count=0; any other byte -> error response.
REQ-019 ARG: digit -> acc = acc*10 + (rxd-0x30), count+1; a 4th digit -> error response; CR with count>=1 -> accept; CR with count=0 -> error; any other byte -> error.
REQ-020 Accept: cmd_mode/cmd_arg SHALL update and cmd_valid SHALL pulse in the cycle after the CR strobe; response = 'K'.
REQ-021 Error: cmd_valid SHALL stay 0 and cmd_mode/cmd_arg SHALL hold; response = 'E'.
REQ-022 Response: RESP1 drives txd=response byte with TX_START for one cycle, waits for SEND_END; RESP2 drives txd=0x0D with TX_START, waits for SEND_END, then -> IDLE.
REQ-023 TX_START SHALL never be reasserted before SEND_END for the previous byte.
REQ-024 ',' received in MODE, COLON or ARG SHALL restart the frame (-> MODE, no response, no error).
REQ-025 Bytes received in RESP1/RESP2 SHALL be discarded.
REQ-026 Timeout counter SHALL clear on every RECEIVE_END and when entering IDLE; in MODE/COLON/ARG, reaching TIMEOUT_CYC cycles with no byte -> IDLE silently, no response.
REQ-027 If RECEIVE_END and timeout expiry coincide, the byte SHALL be processed and the timeout ignored.
REQ-028 Argument arithmetic SHALL use 10 bits; the maximum 999 cannot overflow.

Reset
REQ-029 Reset SHALL force IDLE, TX_START=0, txd=0x00, cmd_valid=0, cmd_mode=0, cmd_arg=0, busy=0, and counters to 0.
REQ-030 Reset asserted mid-frame or mid-response SHALL abort immediately; no partial TX_START or cmd_valid after release.

Structure
REQ-031 ASCII constants (0x2C, 0x3A, 0x0D, 0x30, 'K', 'E') and the FSM state encoding SHALL live in a shared package uart_cmd_pkg.
REQ-032 The TX byte sequencer (RESP1/RESP2 handshake) SHALL be a natural sub-module, uart_resp_tx; all other logic stays flat.

Verification
REQ-033 ",3:125\r" -> one cmd_valid pulse, cmd_mode=3, cmd_arg=125; TX sends 'K' then 0x0D, each only after SEND_END.
REQ-034 ",9:1\r" with MAX_MODE=7 -> 'E',0x0D; no cmd_valid; outputs hold previous values.
REQ-035 ",2:1234\r" -> error on the 4th digit; 'E',0x0D; the trailing "4\r" is discarded or ignored; no cmd_valid.
REQ-036 ",2:5,4:7\r" -> single cmd_valid with mode 4, arg 7; no response for the aborted frame.
REQ-037 ",1:" followed by silence for TIMEOUT_CYC (set to 100) -> IDLE, busy=0, no TX_START; then ",1:0\r" -> accepted, arg 0.
REQ-038 RST_n low during RESP1 -> TX_START, busy and cmd_valid = 0 and state = IDLE; a fresh frame after release is accepted.
